// File: rtl/pp_pipeline_accel_bgr2nv12_stream.sv
`default_nettype none
// ============================================================================
//  Module   : pp_pipeline_accel_bgr2nv12_stream
//  Purpose  : Streams a BGR frame from a FIFO and produces NV12 output.
//             Y is written for every pixel. Interleaved U/V is written for
//             even rows only, one word per column pair.
//  Ports    : ap_clk/ap_rst                  clock, sync active-high reset
//             ap_start/continue/done/idle/ready  block-level handshake
//             dst_rows_* / dst_cols_*        frame height / width FIFOs
//             bgr_mat_*                      pixel input {R,G,B}
//             y_out_*                        8-bit luma output
//             uv_out_*                       16-bit chroma output {V,U}
//  Config   : BGR2NV12_CHROMA_AVG_EN - when defined, each U/V word is the
//             rounded average of a horizontal pixel pair instead of the
//             left pixel's value.
//  Revision : 1.0 - initial release
// ============================================================================
module pp_pipeline_accel_bgr2nv12_stream #(
    parameter int DIM_W = 16
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    input  logic        ap_continue,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [31:0] dst_rows_dout,
    input  logic        dst_rows_empty_n,
    output logic        dst_rows_read,
    input  logic [31:0] dst_cols_dout,
    input  logic        dst_cols_empty_n,
    output logic        dst_cols_read,
    input  logic [23:0] bgr_mat_dout,
    input  logic        bgr_mat_empty_n,
    output logic        bgr_mat_read,
    output logic [7:0]  y_out_din,
    input  logic        y_out_full_n,
    output logic        y_out_write,
    output logic [15:0] uv_out_din,
    input  logic        uv_out_full_n,
    output logic        uv_out_write
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] rows_q, rows_d, cols_q, cols_d;
    logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
    logic             done_reg_q, done_reg_d;
    logic             rst_dly_q;

    // Upper dimension bits are intentionally ignored.
    logic unused_dim_bits;
    assign unused_dim_bits = ^{dst_rows_dout[31:DIM_W], dst_cols_dout[31:DIM_W]};

    // ------------------------------------------------------------------
    // Colour conversion on the pixel currently at the FIFO head
    // ------------------------------------------------------------------
    function automatic logic [7:0] clamp8(input logic signed [17:0] v);
        if (v < 18'sd0)
            return 8'd0;
        else if (v > 18'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    logic signed [17:0] r_s, g_s, b_s, y_sum, u_sum, v_sum;
    logic [7:0]         y_pix, u_pix, v_pix, u_out, v_out;

    assign r_s   = $signed({10'd0, bgr_mat_dout[23:16]});
    assign g_s   = $signed({10'd0, bgr_mat_dout[15:8]});
    assign b_s   = $signed({10'd0, bgr_mat_dout[7:0]});
    assign y_sum = ((18'sd66 * r_s + 18'sd129 * g_s + 18'sd25 * b_s + 18'sd128) >>> 8) + 18'sd16;
    assign u_sum = ((18'sd112 * b_s - 18'sd38 * r_s - 18'sd74 * g_s + 18'sd128) >>> 8) + 18'sd128;
    assign v_sum = ((18'sd112 * r_s - 18'sd94 * g_s - 18'sd18 * b_s + 18'sd128) >>> 8) + 18'sd128;
    assign y_pix = clamp8(y_sum);
    assign u_pix = clamp8(u_sum);
    assign v_pix = clamp8(v_sum);

    // ------------------------------------------------------------------
    // Scan position and handshake qualifiers
    // ------------------------------------------------------------------
    logic strobe_en, zero_dim, last_col, last_row, row_even, col_even;
    logic uv_due, accept, dims_go;

    // Strobes are suppressed while in reset and for one cycle after it.
    assign strobe_en = !ap_rst && !rst_dly_q;
    assign zero_dim  = (rows_q == '0) || (cols_q == '0);
    assign last_col  = (col_q == cols_q - DIM_W'(1));
    assign last_row  = (row_q == rows_q - DIM_W'(1));
    assign row_even  = !row_q[0];
    assign col_even  = !col_q[0];

`ifdef BGR2NV12_CHROMA_AVG_EN
    logic [7:0] u_hold_q, u_hold_d, v_hold_q, v_hold_d;
    logic [8:0] u_avg, v_avg;
    logic       hold_load;

    // An even column parks its chroma; the odd partner writes the average.
    // A trailing even column (odd width) has no partner and writes its own.
    assign hold_load = row_even && col_even && !last_col;
    assign uv_due    = row_even && (!col_even || last_col);
    assign u_avg     = {1'b0, u_hold_q} + {1'b0, u_pix} + 9'd1;
    assign v_avg     = {1'b0, v_hold_q} + {1'b0, v_pix} + 9'd1;
    assign u_out     = col_even ? u_pix : u_avg[8:1];
    assign v_out     = col_even ? v_pix : v_avg[8:1];
`else
    assign uv_due = row_even && col_even;
    assign u_out  = u_pix;
    assign v_out  = v_pix;
`endif

    assign accept  = strobe_en && (state_q == ST_RUN) && !zero_dim && bgr_mat_empty_n
                     && y_out_full_n && (uv_out_full_n || !uv_due);
    assign dims_go = strobe_en && (state_q == ST_IDLE) && ap_start && dst_rows_empty_n
                     && dst_cols_empty_n && !done_reg_q;

    assign dst_rows_read = dims_go;
    assign dst_cols_read = dims_go;
    assign bgr_mat_read  = accept;
    assign y_out_write   = accept;
    assign uv_out_write  = accept && uv_due;
    assign y_out_din     = y_out_write ? y_pix : 8'd0;
    assign uv_out_din    = uv_out_write ? {v_out, u_out} : 16'd0;
    assign ap_done       = strobe_en && ((state_q == ST_FIN) || done_reg_q);
    assign ap_ready      = strobe_en && (state_q == ST_FIN);
    assign ap_idle       = (state_q == ST_IDLE) && !ap_start;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        row_d      = row_q;
        col_d      = col_q;
        done_reg_d = done_reg_q;
`ifdef BGR2NV12_CHROMA_AVG_EN
        u_hold_d   = u_hold_q;
        v_hold_d   = v_hold_q;
        if (accept && hold_load) begin
            u_hold_d = u_pix;
            v_hold_d = v_pix;
        end
`endif
        if (ap_continue)
            done_reg_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dims_go) begin
                    rows_d  = dst_rows_dout[DIM_W-1:0];
                    cols_d  = dst_cols_dout[DIM_W-1:0];
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (zero_dim) begin
                    state_d = ST_FIN;
                end else if (accept) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + DIM_W'(1);
                        if (last_row)
                            state_d = ST_FIN;
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            ST_FIN: begin
                // A continue seen in the done cycle acknowledges it at once,
                // so the done flag is only kept when it has not been taken.
                done_reg_d = !ap_continue;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        rst_dly_q <= ap_rst;
        if (ap_rst) begin
            state_q    <= ST_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            done_reg_q <= 1'b0;
`ifdef BGR2NV12_CHROMA_AVG_EN
            u_hold_q   <= 8'd0;
            v_hold_q   <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            row_q      <= row_d;
            col_q      <= col_d;
            done_reg_q <= done_reg_d;
`ifdef BGR2NV12_CHROMA_AVG_EN
            u_hold_q   <= u_hold_d;
            v_hold_q   <= v_hold_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pp_pipeline_accel_bgr2nv12_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pp_pipeline_accel_bgr2nv12_stream
//  Purpose  : Self-checking bench for pp_pipeline_accel_bgr2nv12_stream.
//             Input FIFOs and output sinks are modelled with queues; the
//             expected Y/UV streams come from an arithmetic colour model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pp_pipeline_accel_bgr2nv12_stream;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_continue = 1'b1;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] dst_rows_dout = 32'd0;
    logic        dst_rows_empty_n = 1'b0;
    logic        dst_rows_read;
    logic [31:0] dst_cols_dout = 32'd0;
    logic        dst_cols_empty_n = 1'b0;
    logic        dst_cols_read;
    logic [23:0] bgr_mat_dout = 24'd0;
    logic        bgr_mat_empty_n = 1'b0;
    logic        bgr_mat_read;
    logic [7:0]  y_out_din;
    logic        y_out_full_n = 1'b0;
    logic        y_out_write;
    logic [15:0] uv_out_din;
    logic        uv_out_full_n = 1'b0;
    logic        uv_out_write;

    pp_pipeline_accel_bgr2nv12_stream #(.DIM_W(16)) dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .ap_start         (ap_start),
        .ap_continue      (ap_continue),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .dst_rows_dout    (dst_rows_dout),
        .dst_rows_empty_n (dst_rows_empty_n),
        .dst_rows_read    (dst_rows_read),
        .dst_cols_dout    (dst_cols_dout),
        .dst_cols_empty_n (dst_cols_empty_n),
        .dst_cols_read    (dst_cols_read),
        .bgr_mat_dout     (bgr_mat_dout),
        .bgr_mat_empty_n  (bgr_mat_empty_n),
        .bgr_mat_read     (bgr_mat_read),
        .y_out_din        (y_out_din),
        .y_out_full_n     (y_out_full_n),
        .y_out_write      (y_out_write),
        .uv_out_din       (uv_out_din),
        .uv_out_full_n    (uv_out_full_n),
        .uv_out_write     (uv_out_write)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rows_fq[$];
    logic [31:0] cols_fq[$];
    logic [23:0] pix_q[$];
    logic [7:0]  exp_y[$];
    logic [7:0]  got_y[$];
    logic [15:0] exp_uv[$];
    logic [15:0] got_uv[$];

    int n_rows_rd = 0, n_cols_rd = 0, n_pix_rd = 0, n_exp_pix = 0;
    int done_edges = 0, done_hi = 0;
    logic prev_done = 1'b0;
    int stall_pct = 0;
    int y_force = 0;
    logic [6:0] s_strobes;
    logic       s_idle, s_done, s_dims_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int clampi(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic logic [7:0] ref_y(input logic [23:0] p);
        int r = p[23:16], g = p[15:8], b = p[7:0];
        return 8'(clampi(((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16));
    endfunction

    function automatic logic [7:0] ref_u(input logic [23:0] p);
        int r = p[23:16], g = p[15:8], b = p[7:0];
        return 8'(clampi(((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128));
    endfunction

    function automatic logic [7:0] ref_v(input logic [23:0] p);
        int r = p[23:16], g = p[15:8], b = p[7:0];
        return 8'(clampi(((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128));
    endfunction

    // mode 0: random pixels, 1: constant cval, 2: first pixel red then black
    task automatic load_frame(input int rows, input int cols, input int mode, input logic [23:0] cval);
        logic [23:0] p;
        int uh, vh, u, v;
        uh = 0;
        vh = 0;
        rows_fq.push_back({16'($urandom), 16'(rows)});
        cols_fq.push_back({16'($urandom), 16'(cols)});
        n_exp_pix = rows * cols;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (mode == 0)      p = 24'($urandom);
                else if (mode == 1) p = cval;
                else                p = (r == 0 && c == 0) ? 24'hFF0000 : 24'h000000;
                pix_q.push_back(p);
                exp_y.push_back(ref_y(p));
                u = ref_u(p);
                v = ref_v(p);
                if (r % 2 == 0) begin
`ifdef BGR2NV12_CHROMA_AVG_EN
                    if (c % 2 == 1)
                        exp_uv.push_back({8'((vh + v + 1) / 2), 8'((uh + u + 1) / 2)});
                    else if (c == cols - 1)
                        exp_uv.push_back({8'(v), 8'(u)});
                    else begin
                        uh = u;
                        vh = v;
                    end
`else
                    if (c % 2 == 0)
                        exp_uv.push_back({8'(v), 8'(u)});
`endif
                end
            end
        end
    endtask

    // One clock: drive at negedge, sample 1 unit later, return after posedge.
    task automatic cycle_io();
        logic saw_rd;
        @(negedge ap_clk);
        dst_rows_empty_n = (rows_fq.size() > 0);
        dst_rows_dout    = (rows_fq.size() > 0) ? rows_fq[0] : $urandom;
        dst_cols_empty_n = (cols_fq.size() > 0);
        dst_cols_dout    = (cols_fq.size() > 0) ? cols_fq[0] : $urandom;
        bgr_mat_empty_n  = (pix_q.size() > 0) && ($urandom_range(99) >= stall_pct);
        bgr_mat_dout     = (pix_q.size() > 0) ? pix_q[0] : 24'($urandom);
        y_out_full_n     = (y_force == 0) && ($urandom_range(99) >= stall_pct);
        uv_out_full_n    = ($urandom_range(99) >= stall_pct);
        #1;
        s_strobes = {dst_rows_read, dst_cols_read, bgr_mat_read, y_out_write, uv_out_write, ap_done, ap_ready};
        s_idle    = ap_idle;
        s_done    = ap_done;
        s_dims_rd = dst_rows_read | dst_cols_read;
        if (y_force > 0) begin
            check_eq("stall_strobes", {29'd0, bgr_mat_read, y_out_write, uv_out_write}, 32'd0);
            y_force--;
        end
        if (!bgr_mat_empty_n)  check_eq("bgr_rd_empty", bgr_mat_read, 0);
        if (!y_out_full_n)     check_eq("y_wr_full", y_out_write, 0);
        if (!uv_out_full_n)    check_eq("uv_wr_full", uv_out_write, 0);
        if (!dst_rows_empty_n) check_eq("rows_rd_empty", dst_rows_read, 0);
        if (!y_out_write)      check_eq("y_din_idle", y_out_din, 0);
        if (!uv_out_write)     check_eq("uv_din_idle", uv_out_din, 0);
        check_eq("rd_pair", dst_rows_read, dst_cols_read);
        saw_rd = dst_rows_read;
        if (dst_rows_read && rows_fq.size() > 0) begin void'(rows_fq.pop_front()); n_rows_rd++; end
        if (dst_cols_read && cols_fq.size() > 0) begin void'(cols_fq.pop_front()); n_cols_rd++; end
        if (bgr_mat_read && pix_q.size() > 0)    begin void'(pix_q.pop_front()); n_pix_rd++; end
        if (y_out_write)  got_y.push_back(y_out_din);
        if (uv_out_write) got_uv.push_back(uv_out_din);
        if (ap_done && !prev_done) done_edges++;
        if (ap_done) done_hi++;
        prev_done = ap_done;
        @(posedge ap_clk);
        #1;
        if (saw_rd) ap_start = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int force_at, input int y0, input int uv0,
                                output int done_cyc);
        int cyc, e0, rr0, cr0, pr0, hi_seen;
        bit seen;
        cyc = 0; seen = 0;
        e0 = done_edges; rr0 = n_rows_rd; cr0 = n_cols_rd; pr0 = n_pix_rd;
        ap_start = 1'b1;
        while (!seen && cyc < 3000) begin
            if (cyc == force_at) y_force = 3;
            cycle_io();
            cyc++;
            if (done_edges != e0) seen = 1;
        end
        done_cyc = cyc;
        check_eq({tag, "_done_seen"}, seen, 1);
        if (ap_continue) begin
            hi_seen = done_hi;
            cycle_io();
            cycle_io();
            check_eq({tag, "_done_extra"}, done_hi - hi_seen, 0);
            check_eq({tag, "_done_edges"}, done_edges - e0, 1);
        end
        check_eq({tag, "_rows_rd"}, n_rows_rd - rr0, 1);
        check_eq({tag, "_cols_rd"}, n_cols_rd - cr0, 1);
        check_eq({tag, "_pix_rd"}, n_pix_rd - pr0, n_exp_pix);
        check_eq({tag, "_ny"}, got_y.size(), exp_y.size());
        check_eq({tag, "_nuv"}, got_uv.size(), exp_uv.size());
        for (int i = 0; i < got_y.size() && i < exp_y.size(); i++)
            check_eq($sformatf("%s_y%0d", tag, i), got_y[i], exp_y[i]);
        for (int i = 0; i < got_uv.size() && i < exp_uv.size(); i++)
            check_eq($sformatf("%s_uv%0d", tag, i), got_uv[i], exp_uv[i]);
        if (y0 >= 0)  check_eq({tag, "_y0_const"}, (got_y.size() > 0) ? 32'(got_y[0]) : 32'hDEAD, y0);
        if (uv0 >= 0) check_eq({tag, "_uv0_const"}, (got_uv.size() > 0) ? 32'(got_uv[0]) : 32'hDEAD, uv0);
        exp_y.delete(); got_y.delete(); exp_uv.delete(); got_uv.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        // reset with a pending request: nothing may move
        ap_rst = 1'b1;
        repeat (3) begin
            cycle_io();
            check_eq("rst_quiet", s_strobes, 0);
        end
        ap_rst = 1'b0;
        cycle_io();
        check_eq("post_rst_quiet", s_strobes, 0);
        check_eq("rst_idle", s_idle, 1);

        load_frame(2, 2, 1, 24'hFFFFFF);
        finish_frame("white2x2", -1, 8'hEB, 16'h8080, dc);

        load_frame(2, 4, 1, 24'hFF0000);
        finish_frame("red4x2", -1, 8'h52, 16'hF05A, dc);

        load_frame(1, 2, 2, 24'h0);
`ifdef BGR2NV12_CHROMA_AVG_EN
        finish_frame("pair2x1", -1, 8'h52, 16'hB86D, dc);
`else
        finish_frame("pair2x1", -1, 8'h52, 16'hF05A, dc);
`endif

        load_frame(4, 4, 0, 24'h0);
        finish_frame("stall4x4", 4, -1, -1, dc);

        load_frame(0, 8, 0, 24'h0);
        finish_frame("zero_rows", -1, -1, -1, dc);
        check_eq("zero_rows_latency_ok", dc <= 3, 1);

        // done held while continue is low; queued start must be refused
        ap_continue = 1'b0;
        load_frame(3, 3, 0, 24'h0);
        finish_frame("hold_a", -1, -1, -1, dc);
        load_frame(2, 2, 0, 24'h0);
        ap_start = 1'b1;
        repeat (5) begin
            cycle_io();
            check_eq("hold_done", s_done, 1);
            check_eq("hold_no_rd", s_dims_rd, 0);
        end
        ap_continue = 1'b1;
        finish_frame("hold_b", -1, -1, -1, dc);

        // reset in the middle of a frame, then a clean frame
        stall_pct = 20;
        load_frame(4, 4, 0, 24'h0);
        ap_start = 1'b1;
        repeat (12) cycle_io();
        ap_rst = 1'b1;
        rows_fq.delete(); cols_fq.delete(); pix_q.delete();
        exp_y.delete(); got_y.delete(); exp_uv.delete(); got_uv.delete();
        repeat (2) begin
            cycle_io();
            check_eq("mid_rst_quiet", s_strobes, 0);
        end
        load_frame(2, 3, 0, 24'h0);
        ap_start = 1'b1;
        ap_rst = 1'b0;
        cycle_io();
        check_eq("mid_post_rst_quiet", s_strobes, 0);
        finish_frame("rst_recover", -1, -1, -1, dc);

        // random dimensions and random back-pressure
        stall_pct = 30;
        for (int k = 0; k < 6; k++) begin
            load_frame($urandom_range(1, 5), $urandom_range(1, 7), 0, 24'h0);
            finish_frame($sformatf("rand%0d", k), -1, -1, -1, dc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
